// File: rtl/nios_pio_pkg.sv
// Shared definitions for the Nios bidirectional PIO: register word addresses,
// edge-capture condition codes and the per-bit edge qualifier.
package nios_pio_pkg;

  localparam logic [2:0] ADDR_DATA         = 3'd0;
  localparam logic [2:0] ADDR_DIRECTION    = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK     = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAPTURE = 3'd3;
  localparam logic [2:0] ADDR_OUTSET       = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR     = 3'd5;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  function automatic logic edge_event(input logic cur, input logic prev, input int edge_type);
    case (edge_type)
      EDGE_RISING:  return cur & ~prev;
      EDGE_FALLING: return ~cur & prev;
      default:      return cur ^ prev;
    endcase
  endfunction

endpackage

// File: rtl/nios_bidir_pio_sync.sv
// WIDTH-wide, SYNC_STAGES-deep flop chain bringing the asynchronous pin values
// into the clk domain.
module nios_bidir_pio_sync #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pins,
  output logic [WIDTH-1:0] synced
);

  logic [WIDTH-1:0] stages [SYNC_STAGES];

  always_ff @(posedge clk) begin
    // NOTE: this array is a flop chain, not RAM, so every stage is reset; an
    // unreset stage would leak power-up garbage into the edge detector.
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) stages[s] <= '0;
    end else begin
      stages[0] <= pins;
      for (int s = 1; s < SYNC_STAGES; s++) stages[s] <= stages[s-1];
    end
  end

  assign synced = stages[SYNC_STAGES-1];

endmodule

// File: rtl/nios_bidir_pio.sv
// Avalon-MM bidirectional PIO: per-bit direction, atomic set/clear, synchronised inputs.
// Define NIOS_BIDIR_PIO_EDGE_IRQ_EN to build the edge-capture registers and irq.
module nios_bidir_pio
  import nios_pio_pkg::*;
#(
  parameter int               WIDTH       = 4,
  parameter int               SYNC_STAGES = 2,
  parameter int               EDGE_TYPE   = EDGE_RISING,
  parameter logic [WIDTH-1:0] RESET_DIR   = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  inout  wire  [WIDTH-1:0] bidir_port,
  output logic             irq
);

  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] direction;
  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] wdata;
  logic [31:0]      rd_word;
  logic             wr;
  logic             unused_cfg;

  assign wr         = chipselect && !write_n;
  assign wdata      = writedata[WIDTH-1:0];
  assign unused_cfg = ^{writedata, 2'(EDGE_TYPE)};

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    assign bidir_port[i] = direction[i] ? data_out[i] : 1'bz;
  end

  nios_bidir_pio_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .reset  (reset),
    .pins   (bidir_port),
    .synced (sync_in)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out  <= '0;
      direction <= RESET_DIR;
    end else if (wr) begin
      case (address)
        ADDR_DATA:      data_out  <= wdata;
        ADDR_DIRECTION: direction <= wdata;
        ADDR_OUTSET:    data_out  <= data_out | wdata;
        ADDR_OUTCLEAR:  data_out  <= data_out & ~wdata;
        default:        ;
      endcase
    end
  end

`ifdef NIOS_BIDIR_PIO_EDGE_IRQ_EN
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] prev_in;
  logic [WIDTH-1:0] edge_hit;
  logic             armed;

  always_comb begin
    edge_hit = '0;
    if (armed) begin
      for (int i = 0; i < WIDTH; i++) edge_hit[i] = edge_event(sync_in[i], prev_in[i], EDGE_TYPE);
    end
  end

  // A fresh edge is OR-ed in after the clear so it survives a same-cycle write-1-clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_mask     <= '0;
      edge_capture <= '0;
      prev_in      <= '0;
      armed        <= 1'b0;
    end else begin
      armed   <= 1'b1;
      prev_in <= sync_in;
      if (wr && address == ADDR_IRQ_MASK) irq_mask <= wdata;
      if (wr && address == ADDR_EDGE_CAPTURE) edge_capture <= (edge_capture & ~wdata) | edge_hit;
      else                                    edge_capture <= edge_capture | edge_hit;
    end
  end

  assign irq = |(edge_capture & irq_mask);
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    // NOTE: the default first keeps every path assigned, so no latch is inferred.
    rd_word = '0;
    case (address)
      ADDR_DATA:         rd_word[WIDTH-1:0] = sync_in;
      ADDR_DIRECTION:    rd_word[WIDTH-1:0] = direction;
`ifdef NIOS_BIDIR_PIO_EDGE_IRQ_EN
      ADDR_IRQ_MASK:     rd_word[WIDTH-1:0] = irq_mask;
      ADDR_EDGE_CAPTURE: rd_word[WIDTH-1:0] = edge_capture;
`endif
      default:           rd_word = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) readdata <= '0;
    else       readdata <= rd_word;
  end

endmodule

// File: doc/nios_bidir_pio.md
# nios_bidir_pio

Parametrised bidirectional parallel I/O port, an Avalon-MM slave on the Nios system bus. Generalises the fixed 4-bit SD data port to WIDTH pins. Adds:
- per-bit direction;
- atomic set/clear of output bits;
- a multi-stage input synchroniser;
- optional edge capture with a masked interrupt request.

It sits between the system interconnect and FPGA top-level inout pins, for example the SD card DAT lines or generic GPIO banks.

## Interface
- WIDTH, 4 — number of bidirectional pins (1..32).
- SYNC_STAGES, 2 — input synchroniser flops (2..4).
- EDGE_TYPE, 0 — capture condition: 0 rising, 1 falling, 2 any edge.
- RESET_DIR, 0 — reset value of the direction register (WIDTH bits); 0 means all inputs.
- clk  input  1  system clock; everything is single-clock.
- reset  input  1  synchronous, active-high reset.
- address  input  3  register word index.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe, qualified by chipselect.
- writedata  input  32  write data; bits above WIDTH are ignored.
- readdata  output  32  registered read data, zero-extended.
- bidir_port  inout  WIDTH  external pins.
- irq  output  1  level interrupt request.

## Operation
Register map (word addresses):
- 0 DATA: read returns the synchronised pin value. Write loads data_out.
- 1 DIRECTION: bit=1 drives that pin from data_out; bit=0 tristates it. Read/write.
- 2 IRQ_MASK: read/write.
- 3 EDGE_CAPTURE: read returns captured edges. Writing 1 clears the bit; writing 0 leaves it unchanged.
- 4 OUTSET: write ORs writedata into data_out. Reads 0.
- 5 OUTCLEAR: write clears data_out bits where writedata is 1. Reads 0.
- 6, 7: reads 0; writes ignored.

Behaviour:
- A write occurs when chipselect=1 and write_n=0 at a clk edge.
- Pin drive: bidir_port[i] = direction[i] ? data_out[i] : Z.
- Input path: every pin passes through SYNC_STAGES flops, giving sync_in. This applies to driven pins too, so reading back a driven pin returns its own value.
- Edge detect compares sync_in with a one-cycle-delayed copy, prev_in. A detected edge sets edge_capture[i], which stays set until software clears it.
- irq = |(edge_capture & irq_mask). irq is combinational from registers and carries no extra flop.
- Simultaneous edge event and write-1-clear on the same bit: the set wins, and the bit stays 1.
- Reset:
  - data_out, irq_mask, edge_capture, readdata = 0.
  - direction = RESET_DIR.
  - Synchroniser and prev_in flops = 0.
  - irq = 0.
  - All pins are tristated when RESET_DIR = 0.
- Reset asserted mid-operation overrides any concurrent write in that cycle.
- To avoid a spurious edge after reset, the first edge compare is suppressed: a one-bit armed flag is set one cycle after reset deasserts.

## Timing
- Read latency 1: readdata reflects the address sampled at edge N, valid after edge N. readdata updates every cycle, independent of chipselect.
- Write takes effect at the edge where it is sampled. A pin changes in the same cycle as a DATA, OUTSET, OUTCLEAR or DIRECTION write.
- Pin change to DATA readback: visible in sync_in after SYNC_STAGES edges, and in readdata one edge later.
- Pin change to edge_capture/irq: SYNC_STAGES+1 edges.
- No wait states and no back-pressure.

## Configuration
- NIOS_BIDIR_PIO_EDGE_IRQ_EN defined: IRQ_MASK and EDGE_CAPTURE registers, the edge detector and irq are implemented as above.
- Not defined:
  - Those registers and the prev_in flops are removed.
  - Addresses 2 and 3 read 0 and ignore writes.
  - irq is tied to 0.
  - The DATA, DIRECTION, OUTSET and OUTCLEAR behaviour is unchanged.

## Structure
- Shared package nios_pio_pkg:
  - register address constants ADDR_DATA … ADDR_OUTCLEAR;
  - edge type constants EDGE_RISING/EDGE_FALLING/EDGE_ANY.
- Sub-module nios_bidir_pio_sync: WIDTH-wide, SYNC_STAGES-deep synchroniser with synchronous active-high reset to 0. It is instantiated once.

## Test plan
- Reset and direction: reset, then external pins driven to 0xA. Require: readdata at address 0 is 0xA after SYNC_STAGES+1 cycles, and the bench sees bidir_port=Z.
- Output drive and set/clear:
  - write DIRECTION=0xF, then DATA=0x5 → pins 0x5 on the next cycle;
  - then OUTSET 0x8 → 0xD;
  - then OUTCLEAR 0x1 → 0xC.
- Mixed direction: DIRECTION=0x3, data_out=0x3, external driver on bits 3:2 = 0x2 → DATA reads 0xB.
- Edge and interrupt (EDGE_TYPE=0, EDGE_IRQ_EN defined):
  - IRQ_MASK=0x1; pin0 rises → irq=1 exactly SYNC_STAGES+1 cycles later, and EDGE_CAPTURE reads 0x1;
  - write 0x1 to EDGE_CAPTURE → irq=0 next cycle.
- Clear/set collision: a pin0 edge registers in the same cycle as a write-1-clear of EDGE_CAPTURE → bit stays 1 and irq stays 1.
- Macro undefined build: toggle pins and write 0xF to addresses 2 and 3 → both read 0 and irq never asserts.
